wb_arbiter: RTL and testbench

Write-back arbiter for the pipelined MIPS core: the single driver of the register bank's write port (reg_write, write_reg, write_data). It merges the in-order WB-stage write with results from long-latency units (multiply/divide, future cache-miss loads), buffering the latter in a small FIFO until a free write slot appears. It also gives decode a pending-write lookup so hazard logic can stall on registers that still have a queued write.

---
 rtl/wb_arbiter_pkg.sv | 18 +
 rtl/wb_fifo.sv | 70 +++++++
 rtl/wb_arbiter.sv | 144 ++++++++++++++
 tb/tb_wb_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared definitions for the write-back arbiter slice.
//   - default data / register-index widths
//   - REG_ZERO: index of the hard-wired zero register (writes to it are no-ops)
//   - rf_src_e: which source drives the register-bank write port this cycle
// FIFO entries are packed as {reg, data}, with the register index in the MSBs.
package wb_arbiter_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int REG_ZERO   = 0;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_PIPE = 2'd1,
    SRC_FIFO = 2'd2
  } rf_src_e;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO holding long-latency results until a free write slot.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   push, push_entry      enqueue (caller guarantees not full)
//   pop                   dequeue head (caller guarantees not empty)
//   head_entry            oldest entry, valid whenever count != 0
//   count                 occupancy, registered
//   entry_valid/entry_tag per-slot valid bit and tag (top TAG_W bits of the
//                         entry) so the owner can search queued destinations
module wb_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 37,
  parameter int TAG_W = 5
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             push,
  input  logic [WIDTH-1:0]                 push_entry,
  input  logic                             pop,
  output logic [WIDTH-1:0]                 head_entry,
  output logic [$clog2(DEPTH+1)-1:0]       count,
  output logic [DEPTH-1:0]                 entry_valid,
  output logic [DEPTH-1:0][TAG_W-1:0]      entry_tag
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  // Control state. DEPTH is a power of two, so pointers wrap by overflow.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      entry_valid <= '0;
    end else begin
      if (push) begin
        entry_valid[wr_ptr] <= 1'b1;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop) begin
        entry_valid[rd_ptr] <= 1'b0;
        rd_ptr              <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; entry_valid and count
  // qualify every read, so stale data is never observed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  assign head_entry = mem[rd_ptr];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) entry_tag[i] = mem[i][WIDTH-1 -: TAG_W];
  end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: sole driver of the register bank write port.
// The WB-stage write always wins and passes through with zero latency;
// long-latency results queue in wb_fifo and drain into idle WB slots.
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   pipe_wr_en/reg/data              in-order WB-stage write
//   aux_valid/ready/reg/data         long-latency result handshake
//   rf_reg_write/write_reg/data      register bank write port
//   query_reg, query_pending         decode lookup of queued destinations
//   stall_req                        ask for a bubble so the FIFO can drain
//   fifo_count                       FIFO occupancy
//   waw_conflict                     WB write hits a still-queued register
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         pipe_wr_en,
  input  logic [ADDR_W-1:0]            pipe_wr_reg,
  input  logic [DATA_W-1:0]            pipe_wr_data,
  input  logic                         aux_valid,
  output logic                         aux_ready,
  input  logic [ADDR_W-1:0]            aux_reg,
  input  logic [DATA_W-1:0]            aux_data,
  output logic                         rf_reg_write,
  output logic [ADDR_W-1:0]            rf_write_reg,
  output logic [DATA_W-1:0]            rf_write_data,
  input  logic [ADDR_W-1:0]            query_reg,
  output logic                         query_pending,
  output logic                         stall_req,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
  output logic                         waw_conflict
);

  localparam int CNT_W    = $clog2(DEPTH+1);
  localparam int STARVE_W = $clog2(STARVE_LIMIT+1);
  localparam int ENTRY_W  = ADDR_W + DATA_W;

  localparam logic [ADDR_W-1:0]   ZERO_REG  = ADDR_W'(REG_ZERO);
  localparam logic [CNT_W-1:0]    FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [STARVE_W-1:0] STARVE_MX = STARVE_W'(STARVE_LIMIT);

  logic                          pipe_busy;
  logic                          fifo_empty;
  logic                          push;
  logic                          pop;
  rf_src_e                       rf_src;
  logic [ENTRY_W-1:0]            head_entry;
  logic [DEPTH-1:0]              entry_valid;
  logic [DEPTH-1:0][ADDR_W-1:0]  entry_tag;
  logic                          query_hit;
  logic                          pipe_hit;
  logic [STARVE_W-1:0]           starve_cnt;
  logic [STARVE_W-1:0]           starve_next;

  assign pipe_busy  = pipe_wr_en && (pipe_wr_reg != ZERO_REG);
  assign fifo_empty = (fifo_count == '0);

  // Ready depends only on registered occupancy, never on this cycle's pop.
  assign aux_ready = (fifo_count < FULL_CNT) && !reset;
  // Results for the zero register complete the handshake but are dropped.
  assign push      = aux_valid && aux_ready && (aux_reg != ZERO_REG);
  assign pop       = (rf_src == SRC_FIFO);

  wb_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W),
    .TAG_W (ADDR_W)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (push),
    .push_entry  ({aux_reg, aux_data}),
    .pop         (pop),
    .head_entry  (head_entry),
    .count       (fifo_count),
    .entry_valid (entry_valid),
    .entry_tag   (entry_tag)
  );

  // Write-port source: WB stage first, queued result only into an idle slot.
  // NOTE: every output of an always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    rf_src        = SRC_NONE;
    rf_reg_write  = 1'b0;
    rf_write_reg  = '0;
    rf_write_data = '0;
    if (!reset) begin
      if (pipe_busy)        rf_src = SRC_PIPE;
      else if (!fifo_empty) rf_src = SRC_FIFO;
    end
    case (rf_src)
      SRC_PIPE: begin
        rf_reg_write  = 1'b1;
        rf_write_reg  = pipe_wr_reg;
        rf_write_data = pipe_wr_data;
      end
      SRC_FIFO: begin
        rf_reg_write  = 1'b1;
        rf_write_reg  = head_entry[DATA_W +: ADDR_W];
        rf_write_data = head_entry[DATA_W-1:0];
      end
      default: ;
    endcase
  end

  // Destination search over queued entries (same-cycle push not visible).
  always_comb begin
    query_hit = 1'b0;
    pipe_hit  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i] && entry_tag[i] == query_reg)   query_hit = 1'b1;
      if (entry_valid[i] && entry_tag[i] == pipe_wr_reg) pipe_hit  = 1'b1;
    end
  end

  assign query_pending = !reset && (query_reg != ZERO_REG) && query_hit;
  assign waw_conflict  = !reset && pipe_busy && pipe_hit;

  // Starvation: count consecutive cycles the queue waits behind the WB stage.
  always_comb begin
    starve_next = starve_cnt;
    if (pop || fifo_empty)                      starve_next = '0;
    else if (pipe_busy && starve_cnt != STARVE_MX) starve_next = starve_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
      stall_req  <= 1'b0;
    end else begin
      starve_cnt <= starve_next;
      // Once raised, hold until the queue actually gets a slot.
      stall_req  <= pop ? 1'b0 : (stall_req || starve_next == STARVE_MX);
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios followed by a
// randomized run, all compared each cycle against a queue-based model.
module tb_wb_arbiter;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 4;
  localparam int LIMIT  = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              pipe_wr_en;
  logic [ADDR_W-1:0] pipe_wr_reg;
  logic [DATA_W-1:0] pipe_wr_data;
  logic              aux_valid;
  logic              aux_ready;
  logic [ADDR_W-1:0] aux_reg;
  logic [DATA_W-1:0] aux_data;
  logic              rf_reg_write;
  logic [ADDR_W-1:0] rf_write_reg;
  logic [DATA_W-1:0] rf_write_data;
  logic [ADDR_W-1:0] query_reg;
  logic              query_pending;
  logic              stall_req;
  logic [2:0]        fifo_count;
  logic              waw_conflict;

  int checks   = 0;
  int failures = 0;

  // Reference model: the queued writes in arrival order plus starvation run.
  logic [ADDR_W-1:0] mq_reg[$];
  logic [DATA_W-1:0] mq_data[$];
  int                blocked_run = 0;
  bit                m_stall     = 1'b0;

  always #5 clk = ~clk;

  wb_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .reset(reset),
    .pipe_wr_en(pipe_wr_en), .pipe_wr_reg(pipe_wr_reg), .pipe_wr_data(pipe_wr_data),
    .aux_valid(aux_valid), .aux_ready(aux_ready), .aux_reg(aux_reg), .aux_data(aux_data),
    .rf_reg_write(rf_reg_write), .rf_write_reg(rf_write_reg), .rf_write_data(rf_write_data),
    .query_reg(query_reg), .query_pending(query_pending), .stall_req(stall_req),
    .fifo_count(fifo_count), .waw_conflict(waw_conflict)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit in_q(input logic [ADDR_W-1:0] r);
    foreach (mq_reg[i]) if (mq_reg[i] == r) return 1'b1;
    return 1'b0;
  endfunction

  task automatic set_in(input bit rst, input bit pen, input logic [ADDR_W-1:0] preg,
                        input logic [DATA_W-1:0] pdata, input bit av,
                        input logic [ADDR_W-1:0] areg, input logic [DATA_W-1:0] adata,
                        input logic [ADDR_W-1:0] qreg);
    reset = rst; pipe_wr_en = pen; pipe_wr_reg = preg; pipe_wr_data = pdata;
    aux_valid = av; aux_reg = areg; aux_data = adata; query_reg = qreg;
  endtask

  // Compare every output against the model at the falling edge.
  task automatic cyc();
    bit                busy;
    bit                e_we;
    logic [ADDR_W-1:0] e_reg;
    logic [DATA_W-1:0] e_data;
    @(negedge clk);
    busy = pipe_wr_en && pipe_wr_reg != 0;
    e_we = 1'b0; e_reg = '0; e_data = '0;
    if (!reset) begin
      if (busy) begin
        e_we = 1'b1; e_reg = pipe_wr_reg; e_data = pipe_wr_data;
      end else if (mq_reg.size() > 0) begin
        e_we = 1'b1; e_reg = mq_reg[0]; e_data = mq_data[0];
      end
    end
    check("rf_reg_write",  rf_reg_write,  e_we);
    check("rf_write_reg",  rf_write_reg,  e_reg);
    check("rf_write_data", rf_write_data, e_data);
    check("aux_ready",     aux_ready,     !reset && mq_reg.size() < DEPTH);
    check("query_pending", query_pending, !reset && query_reg != 0 && in_q(query_reg));
    check("waw_conflict",  waw_conflict,  !reset && busy && in_q(pipe_wr_reg));
    check("fifo_count",    fifo_count,    mq_reg.size());
    check("stall_req",     stall_req,     m_stall);
  endtask

  // Advance the model across the rising edge using the held inputs.
  task automatic tick();
    bit busy;
    bit popped;
    bit pushed;
    int sz;
    @(posedge clk);
    if (reset) begin
      mq_reg.delete(); mq_data.delete();
      blocked_run = 0; m_stall = 1'b0;
    end else begin
      busy   = pipe_wr_en && pipe_wr_reg != 0;
      sz     = mq_reg.size();
      popped = !busy && sz > 0;
      pushed = aux_valid && sz < DEPTH && aux_reg != 0;
      if (popped) begin
        void'(mq_reg.pop_front()); void'(mq_data.pop_front());
      end
      if (pushed) begin
        mq_reg.push_back(aux_reg); mq_data.push_back(aux_data);
      end
      if (popped || sz == 0)           blocked_run = 0;
      else if (busy && blocked_run < LIMIT) blocked_run++;
      if (popped)                      m_stall = 1'b0;
      else if (blocked_run >= LIMIT)   m_stall = 1'b1;
    end
    #1;
  endtask

  initial begin
    int                bias;
    logic [ADDR_W-1:0] preg;
    logic [ADDR_W-1:0] areg;
    logic [ADDR_W-1:0] qreg;

    // Reset held two cycles with a result offered.
    set_in(1, 0, 0, 0, 1, 5, 32'h55, 0);
    repeat (2) begin
      cyc();
      check("rst_aux_ready", aux_ready, 0);
      check("rst_rf_write", rf_reg_write, 0);
      check("rst_count", fifo_count, 0);
      tick();
    end

    // WB-stage pass-through, then a write to the zero register.
    set_in(0, 1, 7, 32'hDEADBEEF, 0, 0, 0, 0);
    cyc();
    check("pipe7_we", rf_reg_write, 1);
    check("pipe7_reg", rf_write_reg, 7);
    check("pipe7_data", rf_write_data, 32'hDEADBEEF);
    tick();
    set_in(0, 1, 0, 32'h1234, 0, 0, 0, 0);
    cyc();
    check("pipe0_we", rf_reg_write, 0);
    tick();

    // Two results drain into idle slots, reg 3 then reg 4.
    set_in(0, 0, 0, 0, 1, 3, 32'h11, 4);
    cyc(); check("no_bypass", rf_reg_write, 0); tick();
    set_in(0, 0, 0, 0, 1, 4, 32'h22, 4);
    cyc(); check("drain3_reg", rf_write_reg, 3); check("q4_not_yet", query_pending, 0); tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 4);
    cyc(); check("drain4_reg", rf_write_reg, 4); check("q4_pending", query_pending, 1); tick();
    cyc(); check("q4_cleared", query_pending, 0); check("drain_idle", rf_reg_write, 0); tick();

    // Fill behind a busy WB stage; fifth result is held off.
    for (int k = 0; k < 4; k++) begin
      set_in(0, 1, 1, k, 1, 5'(10 + k), 32'(100 + k), 0);
      cyc(); tick();
    end
    set_in(0, 1, 1, 32'h9, 1, 14, 32'h104, 0);
    cyc(); check("full_ready", aux_ready, 0); check("full_count", fifo_count, 4); tick();
    set_in(0, 0, 0, 0, 1, 14, 32'h104, 0);
    cyc(); check("full_pop_reg", rf_write_reg, 10); tick();
    cyc(); check("pushpop_ready", aux_ready, 1); tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(); check("pushpop_count", fifo_count, 3); tick();
    repeat (4) begin cyc(); tick(); end

    // Starvation: one entry stuck behind ten busy cycles.
    set_in(0, 1, 2, 32'h2, 1, 20, 32'h20, 0);
    cyc(); tick();
    set_in(0, 1, 2, 32'h3, 0, 0, 0, 0);
    for (int k = 0; k < 10; k++) begin
      cyc();
      if (k == 7) check("stall_pre", stall_req, 0);
      if (k == 8) check("stall_set", stall_req, 1);
      tick();
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(); check("stall_held", stall_req, 1); check("starve_pop", rf_write_reg, 20); tick();
    cyc(); check("stall_clear", stall_req, 0); tick();

    // WAW hit, then reset with three entries queued.
    set_in(0, 1, 2, 32'h4, 1, 9, 32'h99, 0);
    cyc(); tick();
    set_in(0, 1, 9, 32'h5, 1, 21, 32'h21, 0);
    cyc(); check("waw_pulse", waw_conflict, 1); tick();
    set_in(0, 1, 2, 32'h6, 1, 22, 32'h22, 0);
    cyc(); check("three_queued", fifo_count, 2); tick();
    set_in(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(); tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) begin
      cyc(); check("post_rst_we", rf_reg_write, 0); check("post_rst_count", fifo_count, 0);
      tick();
    end

    // Randomized traffic with phases of varying WB-stage load.
    bias = 50;
    for (int n = 0; n < 400; n++) begin
      if (n % 50 == 0) bias = $urandom_range(10, 95);
      preg = 5'($urandom_range(0, 31));
      if (in_q(preg)) preg = '0;  // decode would have stalled this write
      areg = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      if (mq_reg.size() > 0 && $urandom_range(0, 1) == 1)
        qreg = mq_reg[$urandom_range(0, mq_reg.size() - 1)];
      else
        qreg = 5'($urandom_range(0, 31));
      set_in($urandom_range(0, 99) == 0, $urandom_range(0, 99) < bias, preg, $urandom,
             $urandom_range(0, 1) == 1, areg, $urandom, qreg);
      cyc(); tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
